sram_read_port: RTL and testbench

Single-port controller for the board's 1M×16 asynchronous SRAM, sitting directly upstream of the background loader. It accepts word-read requests (`reading` + `ADDR`), runs the SRAM access with a programmable wait, and returns the word on `DATA_OUT` with a one-cycle `SRAM_done` pulse. A secondary write port lets the host/test path program background images into the same SRAM.

---
 rtl/sram_read_port_if.sv | 22 ++
 rtl/sram_read_port.sv | 133 +++++++++++++
 tb/tb_sram_read_port.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_read_port_if.sv
// Request/response bundle between the background loader (plus host write path)
// and the SRAM read-port controller.
interface sram_read_port_if;
  logic        reading;
  logic [19:0] ADDR;
  logic        wr_req;
  logic [19:0] wr_addr;
  logic [15:0] wr_data;
  logic [15:0] DATA_OUT;
  logic        SRAM_done;
  logic        wr_ack;

  modport master (
    output reading, ADDR, wr_req, wr_addr, wr_data,
    input  DATA_OUT, SRAM_done, wr_ack
  );

  modport slave (
    input  reading, ADDR, wr_req, wr_addr, wr_data,
    output DATA_OUT, SRAM_done, wr_ack
  );
endinterface

// File: rtl/sram_read_port.sv
// Single-port controller for a 1Mx16 asynchronous SRAM: word reads for the
// background loader with a programmable access wait, plus a host write port.
module sram_read_port #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                Clk,
  input  logic                Reset_n,
  sram_read_port_if.slave     bus,
  output logic [19:0]         SRAM_ADDR,
  inout  wire  [15:0]         SRAM_DQ,
  output logic                SRAM_CE_N,
  output logic                SRAM_OE_N,
  output logic                SRAM_WE_N,
  output logic                SRAM_UB_N,
  output logic                SRAM_LB_N
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ACCESS,
    S_RD_DONE,
    S_WAIT_LOW,
    S_WR_ACCESS,
    S_WR_DONE
  } state_t;

  localparam logic [3:0] LP_LAST = 4'(WAIT_CYCLES - 1);

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_cnt;
  logic [19:0] r_addr;
  logic [15:0] r_wdata;
  logic [15:0] r_data_out;
  logic        r_was_wr;
  logic        w_last;
  logic        w_dq_oe;

  assign w_last = (r_cnt == LP_LAST);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // WAIT_LOW holds off until the request that started this access is released.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.reading)     w_next = S_RD_ACCESS;
        else if (bus.wr_req) w_next = S_WR_ACCESS;
      end
      S_RD_ACCESS: if (w_last) w_next = S_RD_DONE;
      S_RD_DONE:   w_next = S_WAIT_LOW;
      S_WAIT_LOW:  if (r_was_wr ? !bus.wr_req : !bus.reading) w_next = S_IDLE;
      S_WR_ACCESS: if (w_last) w_next = S_WR_DONE;
      S_WR_DONE:   w_next = S_WAIT_LOW;
      default:     w_next = S_IDLE;
    endcase
  end

  // Controls decode straight from the state so reset releases them at once.
  always_comb begin
    SRAM_CE_N     = 1'b1;
    SRAM_OE_N     = 1'b1;
    SRAM_WE_N     = 1'b1;
    SRAM_UB_N     = 1'b1;
    SRAM_LB_N     = 1'b1;
    w_dq_oe       = 1'b0;
    bus.SRAM_done = 1'b0;
    bus.wr_ack    = 1'b0;
    case (r_state)
      S_RD_ACCESS: begin
        SRAM_CE_N = 1'b0;
        SRAM_OE_N = 1'b0;
        SRAM_UB_N = 1'b0;
        SRAM_LB_N = 1'b0;
      end
      S_RD_DONE: bus.SRAM_done = 1'b1;
      S_WR_ACCESS: begin
        SRAM_CE_N = 1'b0;
        SRAM_WE_N = 1'b0;
        SRAM_UB_N = 1'b0;
        SRAM_LB_N = 1'b0;
        w_dq_oe   = 1'b1;
      end
      S_WR_DONE: begin
        SRAM_CE_N  = 1'b0;
        SRAM_UB_N  = 1'b0;
        SRAM_LB_N  = 1'b0;
        w_dq_oe    = 1'b1;
        bus.wr_ack = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_cnt      <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_data_out <= '0;
      r_was_wr   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (bus.reading) begin
            r_addr   <= bus.ADDR;
            r_was_wr <= 1'b0;
          end else if (bus.wr_req) begin
            r_addr   <= bus.wr_addr;
            r_wdata  <= bus.wr_data;
            r_was_wr <= 1'b1;
          end
        end
        S_RD_ACCESS: begin
          r_cnt <= r_cnt + 4'd1;
          if (w_last) r_data_out <= SRAM_DQ;
        end
        S_WR_ACCESS: r_cnt <= r_cnt + 4'd1;
        default: ;
      endcase
    end
  end

  assign SRAM_ADDR    = r_addr;
  assign SRAM_DQ      = w_dq_oe ? r_wdata : 'z;
  assign bus.DATA_OUT = r_data_out;

endmodule

// File: tb/tb_sram_read_port.sv
// Directed bench for sram_read_port: behavioural SRAM model, table-driven
// loader reads, and hand sequences for reset, held request, writes, arbitration.
module tb_sram_read_port;
  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  wire  [15:0] SRAM_DQ;
  logic [19:0] SRAM_ADDR;
  logic        SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int oe_low = 0, we_low = 0, done_cnt = 0, ack_cnt = 0, acc_cnt = 0;
  logic prev_done = 1'b0, prev_ack = 1'b0;

  always #10 Clk = ~Clk;
  always @(posedge Clk) cyc++;

  sram_read_port_if bus();

  sram_read_port #(.WAIT_CYCLES(2)) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .bus       (bus),
    .SRAM_ADDR (SRAM_ADDR),
    .SRAM_DQ   (SRAM_DQ),
    .SRAM_CE_N (SRAM_CE_N),
    .SRAM_OE_N (SRAM_OE_N),
    .SRAM_WE_N (SRAM_WE_N),
    .SRAM_UB_N (SRAM_UB_N),
    .SRAM_LB_N (SRAM_LB_N)
  );

  // Asynchronous SRAM model
  logic [15:0] mem [logic [19:0]];
  logic [15:0] mdout;
  always @(Clk or SRAM_ADDR) mdout = mem.exists(SRAM_ADDR) ? mem[SRAM_ADDR] : 16'hDEAD;
  assign SRAM_DQ = (!SRAM_CE_N && !SRAM_OE_N && SRAM_WE_N) ? mdout : 'z;
  always @(posedge SRAM_WE_N) if (!SRAM_CE_N && Reset_n) mem[SRAM_ADDR] = SRAM_DQ;
  always @(negedge SRAM_CE_N) acc_cnt++;

  always @(negedge Clk) begin
    if (!SRAM_OE_N) oe_low++;
    if (!SRAM_WE_N) we_low++;
    if (bus.SRAM_done) done_cnt++;
    if (bus.wr_ack) ack_cnt++;
    if (Reset_n) begin
      checks++;
      a_no_contention: assert (!(dut.w_dq_oe && !SRAM_OE_N)) else begin
        errors++;
        $display("FAIL dq_contention actual=driven_with_oe_low required=no_drive at cycle %0d", cyc);
      end
      checks++;
      if ((bus.SRAM_done && bus.wr_ack) || (bus.SRAM_done && prev_done) || (bus.wr_ack && prev_ack)) begin
        errors++;
        $display("FAIL pulse_shape actual done=%0b ack=%0b prev_done=%0b prev_ack=%0b required=single_exclusive_pulses",
                 bus.SRAM_done, bus.wr_ack, prev_done, prev_ack);
      end
    end
    prev_done <= bus.SRAM_done;
    prev_ack  <= bus.wr_ack;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Loader-style read: hold until done, drop for one cycle, return at IDLE resample
  task automatic do_read(input logic [19:0] a, output logic [15:0] d, output int t, output bit ok);
    bus.reading = 1'b1;
    bus.ADDR    = a;
    ok = 1'b0;
    d  = '0;
    t  = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge Clk);
      if (bus.SRAM_done) begin
        d  = bus.DATA_OUT;
        t  = cyc;
        ok = 1'b1;
        break;
      end
    end
    @(negedge Clk);
    bus.reading = 1'b0;
    @(negedge Clk);
  endtask

  typedef struct {
    logic [19:0] addr;
    logic [15:0] exp;
    int          gap;
  } rd_vec_t;

  rd_vec_t vecs [5];
  logic [15:0] d;
  int t, t_prev, o0, w0, d0, a0, c0;
  bit ok;

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{20'h00010, 16'h1234, 0};
    vecs[1] = '{20'd153601, 16'h0101, 5};
    vecs[2] = '{20'd153602, 16'h0202, 5};
    vecs[3] = '{20'd153603, 16'hFFFF, 5};
    vecs[4] = '{20'h00000, 16'hBEEF, 5};
    mem[20'h00010]  = 16'h1234;
    mem[20'd153601] = 16'h0101;
    mem[20'd153602] = 16'h0202;
    mem[20'd153603] = 16'hFFFF;
    mem[20'h00000]  = 16'hBEEF;
    mem[20'h00020]  = 16'h0000;
    bus.reading = 1'b0;
    bus.ADDR    = '0;
    bus.wr_req  = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;

    // Reset state
    repeat (2) @(negedge Clk);
    chk("rst_ce_n", SRAM_CE_N, 1);
    chk("rst_oe_n", SRAM_OE_N, 1);
    chk("rst_we_n", SRAM_WE_N, 1);
    chk("rst_ub_lb", {SRAM_UB_N, SRAM_LB_N}, 2'b11);
    chk("rst_addr", SRAM_ADDR, 0);
    chk("rst_data_out", bus.DATA_OUT, 0);
    chk("rst_pulses", {bus.SRAM_done, bus.wr_ack}, 0);
    chk("rst_dq_hiz", dut.w_dq_oe, 0);
    Reset_n = 1'b1;

    // Reset mid-read
    bus.reading = 1'b1;
    bus.ADDR    = 20'h00010;
    @(negedge Clk);
    chk("mid_rd_oe_low", {SRAM_CE_N, SRAM_OE_N}, 2'b00);
    #5 Reset_n = 1'b0;
    #1;
    chk("mid_rd_ctrl_high", {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N}, 5'b11111);
    chk("mid_rd_dq_hiz", dut.w_dq_oe, 0);
    chk("mid_rd_data_out", bus.DATA_OUT, 0);
    bus.reading = 1'b0;
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
    chk("mid_rd_no_done", done_cnt, 0);
    chk("mid_rd_data_after", bus.DATA_OUT, 0);

    // Table-driven loader stream
    t_prev = 0;
    foreach (vecs[i]) begin
      o0 = oe_low;
      do_read(vecs[i].addr, d, t, ok);
      chk($sformatf("rd%0d_done_seen", i), ok, 1);
      chk($sformatf("rd%0d_data", i), d, vecs[i].exp);
      chk($sformatf("rd%0d_oe_cycles", i), oe_low - o0, 2);
      chk($sformatf("rd%0d_hold", i), bus.DATA_OUT, vecs[i].exp);
      if (vecs[i].gap != 0) chk($sformatf("rd%0d_gap", i), t - t_prev, vecs[i].gap);
      t_prev = t;
    end

    // Held request: one access only
    d0 = done_cnt; c0 = acc_cnt;
    bus.reading = 1'b1;
    bus.ADDR    = 20'h00010;
    repeat (20) @(negedge Clk);
    bus.reading = 1'b0;
    repeat (3) @(negedge Clk);
    chk("held_done_count", done_cnt - d0, 1);
    chk("held_access_count", acc_cnt - c0, 1);
    chk("held_data", bus.DATA_OUT, 16'h1234);

    // Request dropped during RD_ACCESS still completes
    d0 = done_cnt;
    bus.reading = 1'b1;
    bus.ADDR    = 20'd153602;
    @(negedge Clk);
    bus.reading = 1'b0;
    repeat (6) @(negedge Clk);
    chk("drop_done_count", done_cnt - d0, 1);
    chk("drop_data", bus.DATA_OUT, 16'h0202);
    do_read(20'h00010, d, t, ok);
    chk("drop_next_read", {ok, d}, {1'b1, 16'h1234});

    // Write then read back
    w0 = we_low; a0 = ack_cnt; ok = 1'b0;
    bus.wr_req  = 1'b1;
    bus.wr_addr = 20'h7FFFF;
    bus.wr_data = 16'hA5C3;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      if (!SRAM_WE_N) chk("wr_access_dq", SRAM_DQ, 16'hA5C3);
      if (bus.wr_ack) begin
        ok = 1'b1;
        chk("wr_done_we_n", SRAM_WE_N, 1);
        chk("wr_done_dq_driven", dut.w_dq_oe, 1);
        chk("wr_done_dq", SRAM_DQ, 16'hA5C3);
        break;
      end
    end
    chk("wr_ack_seen", ok, 1);
    @(negedge Clk);
    bus.wr_req = 1'b0;
    repeat (2) @(negedge Clk);
    chk("wr_we_cycles", we_low - w0, 2);
    chk("wr_ack_count", ack_cnt - a0, 1);
    chk("wr_mem", mem[20'h7FFFF], 16'hA5C3);
    do_read(20'h7FFFF, d, t, ok);
    chk("wr_readback", {ok, d}, {1'b1, 16'hA5C3});

    // Arbitration: read wins, write waits for re-raise
    d0 = done_cnt; a0 = ack_cnt; w0 = we_low; ok = 1'b0;
    bus.reading = 1'b1;
    bus.ADDR    = 20'h00010;
    bus.wr_req  = 1'b1;
    bus.wr_addr = 20'h00020;
    bus.wr_data = 16'h5555;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      if (bus.SRAM_done) begin ok = 1'b1; break; end
    end
    chk("arb_read_first", ok, 1);
    chk("arb_read_data", bus.DATA_OUT, 16'h1234);
    chk("arb_no_write_yet", {ack_cnt - a0, we_low - w0}, 0);
    @(negedge Clk);
    bus.reading = 1'b0;
    bus.wr_req  = 1'b0;
    repeat (2) @(negedge Clk);
    chk("arb_still_no_write", ack_cnt - a0, 0);
    bus.wr_req = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      if (bus.wr_ack) begin ok = 1'b1; break; end
    end
    chk("arb_write_ack", ok, 1);
    @(negedge Clk);
    bus.wr_req = 1'b0;
    repeat (2) @(negedge Clk);
    chk("arb_mem", mem[20'h00020], 16'h5555);
    chk("arb_counts", {done_cnt - d0, ack_cnt - a0}, {32'd1, 32'd1});
    chk("arb_data_held", bus.DATA_OUT, 16'h1234);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
